uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART. It owns the oversampling tick, start-bit qualification, mid-bit sampling, LSB-first framing and stop-bit check for one serial input. Completed bytes go into a small FIFO drained by a valid/ready consumer. It sits between the raw `rx` pin and the host-side byte consumer, and replaces free-running per-tick sampling with a sequenced, error-reporting receive path.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 72 +++++++
 rtl/uart_rx_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg : shared receive-path types, default constants, parity helper   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int C_OVERSAMPLE_DEF = 16;
  localparam int C_DATA_BITS_DEF  = 8;
  localparam int C_FIFO_DEPTH_DEF = 4;

  // Expected parity bit; unused upper data bits must be zero.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : synchronous FIFO with wrapping pointers and occupancy     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  // Head is forced to zero when empty so the output has a defined reset value.
  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign push_ok = i_push && (!o_full || i_pop);
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// +--------------------------------------------------------------------------+
// | uart_rx_ctrl : oversampled UART receiver with byte FIFO and error flags  |
// | Optional parity stage: define UART_RX_PARITY_EN.            Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 27,
  parameter int OVERSAMPLE    = C_OVERSAMPLE_DEF,
  parameter int DATA_BITS     = C_DATA_BITS_DEF,
  parameter int FIFO_DEPTH    = C_FIFO_DEPTH_DEF,
  parameter int PARITY_ODD    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          enable,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          clr_overrun
);

  localparam int DW = $clog2(CLKS_PER_TICK + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic                 rx_meta_q, rx_s_q, rx_q_q;
  logic [DW-1:0]        div_q, div_d;
  logic                 tick;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        sc_q, sc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 discard_q, discard_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push_req;
  logic                 fifo_pop, fifo_full, fifo_empty;

  assign tick = (div_q == DW'(CLKS_PER_TICK - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    discard_d    = discard_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push_req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && rx_q_q && !rx_s_q) begin
          state_d   = START;
          sc_d      = '0;
          bit_d     = '0;
          discard_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (sc_q == SW'(OVERSAMPLE / 2 - 1)) begin
            sc_d    = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sc_q == SW'(OVERSAMPLE - 1)) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            sc_d    = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (sc_q == SW'(OVERSAMPLE - 1)) begin
            discard_d = (rx_s_q != parity_bit(8'(shreg_q), PARITY_ODD != 0));
            sc_d      = '0;
            state_d   = STOP;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sc_q == SW'(OVERSAMPLE - 1)) begin
            sc_d    = '0;
            state_d = IDLE;
            if (!rx_s_q) frame_err_d = 1'b1;
            else if (!discard_q) push_req = 1'b1;
`ifdef UART_RX_PARITY_EN
            else parity_err_d = 1'b1;
`endif
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop = m_valid && m_ready;

  // A byte lost to a full FIFO sets the flag; a new loss wins over a clear.
  always_comb begin
    overrun_d = overrun_q;
    if (push_req && fifo_full && !fifo_pop) overrun_d = 1'b1;
    else if (clr_overrun)                   overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_q_q       <= 1'b1;
      div_q        <= '0;
      state_q      <= IDLE;
      sc_q         <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      discard_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_q_q       <= rx_s_q;
      div_q        <= div_d;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      discard_q    <= discard_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (push_req),
    .i_data  (8'(shreg_q)),
    .i_pop   (fifo_pop),
    .o_data  (m_data),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign m_valid    = !fifo_empty;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_uart_rx_ctrl : directed vector bench for uart_rx_ctrl                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_ctrl;

  localparam int CPT = 4;
  localparam int OS  = 16;
  localparam int BIT = CPT * OS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       enable = 1'b0;
  logic       ready_man = 1'b0;
  logic       pop_on_push = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid, busy, frame_err, parity_err, overrun;
  logic [2:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       bad_par = 1'b0;
`endif

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ferr;
    int         count;
    logic [7:0] head;
    logic       ovr;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  // Pops exactly on the edge that pushes, for the full-FIFO corner case.
  assign m_ready = ready_man | (pop_on_push & dut.push_req);

  uart_rx_ctrl #(
    .CLKS_PER_TICK (CPT),
    .OVERSAMPLE    (OS),
    .DATA_BITS     (8),
    .FIFO_DEPTH    (4),
    .PARITY_ODD    (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .enable      (enable),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ef,
                            input logic ep, input int cnt, input logic [7:0] head,
                            input logic ovr, input string nm);
    int t;
    int hi;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(bad_par ? ~(^d) : ^d);
`endif
    rx = stop;
    t  = 0;
    while (busy && t < 3 * BIT) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk({nm, " busy timeout"}, busy, 0);
    chk({nm, " m_valid"}, m_valid, cnt != 0);
    chk({nm, " m_data"}, m_data, head);
    chk({nm, " fifo_count"}, fifo_count, cnt);
    chk({nm, " frame_err"}, frame_err, ef);
    chk({nm, " parity_err"}, parity_err, ep);
    chk({nm, " overrun"}, overrun, ovr);
    @(negedge clk);
    chk({nm, " frame_err one-cycle"}, frame_err, 0);
    if (!stop) begin
      hi = 0;
      repeat (2 * BIT) begin
        @(negedge clk);
        if (busy) hi++;
      end
      chk({nm, " no retrigger on break"}, hi, 0);
      rx = 1'b1;
    end
    repeat (BIT) @(negedge clk);
  endtask

  task automatic drain(input logic [7:0] exp, input string nm);
    chk({nm, " m_valid"}, m_valid, 1);
    chk({nm, " m_data"}, m_data, exp);
    ready_man = 1'b1;
    @(negedge clk);
    ready_man = 1'b0;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, ferr: 1'b0, count: 1, head: 8'hA5, ovr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b1, ferr: 1'b0, count: 2, head: 8'hA5, ovr: 1'b0};
    vecs[2] = '{data: 8'h55, stop: 1'b0, ferr: 1'b1, count: 2, head: 8'hA5, ovr: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, ferr: 1'b0, count: 3, head: 8'hA5, ovr: 1'b0};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, ferr: 1'b0, count: 4, head: 8'hA5, ovr: 1'b0};
    vecs[5] = '{data: 8'h81, stop: 1'b1, ferr: 1'b0, count: 4, head: 8'hA5, ovr: 1'b1};

    repeat (3) @(negedge clk);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_data", m_data, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset parity_err", parity_err, 0);
    chk("reset overrun", overrun, 0);
    reset  = 1'b0;
    enable = 1'b1;
    repeat (BIT) @(negedge clk);

    // Start-bit glitch of 3 ticks is rejected at the half-bit check.
    rx = 1'b0;
    repeat (3 * CPT) @(negedge clk);
    chk("glitch armed busy", busy, 1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("glitch back to idle", busy, 0);
    chk("glitch no push", fifo_count, 0);

    for (int v = 0; v < 6; v++)
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].ferr, 1'b0, vecs[v].count,
                 vecs[v].head, vecs[v].ovr, $sformatf("vec%0d", v));

    drain(8'hA5, "drain0");
    drain(8'h3C, "drain1");
    drain(8'h00, "drain2");
    drain(8'hFF, "drain3");
    chk("drained count", fifo_count, 0);
    chk("drained m_valid", m_valid, 0);
    chk("overrun sticky", overrun, 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("overrun cleared", overrun, 0);

    // Full FIFO with a pop on the push edge: nothing lost, no overrun.
    send_frame(8'h10, 1'b1, 1'b0, 1'b0, 1, 8'h10, 1'b0, "fill0");
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 2, 8'h10, 1'b0, "fill1");
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 3, 8'h10, 1'b0, "fill2");
    send_frame(8'h13, 1'b1, 1'b0, 1'b0, 4, 8'h10, 1'b0, "fill3");
    pop_on_push = 1'b1;
    send_frame(8'h14, 1'b1, 1'b0, 1'b0, 4, 8'h11, 1'b0, "push+pop");
    pop_on_push = 1'b0;
    drain(8'h11, "pp drain0");
    drain(8'h12, "pp drain1");
    drain(8'h13, "pp drain2");
    drain(8'h14, "pp drain3");

    // Reset during data bit 4 aborts the frame and empties the FIFO.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1, 8'h5A, 1'b0, "pre-reset");
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    chk("mid-frame busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset busy", busy, 0);
    chk("mid reset m_valid", m_valid, 0);
    chk("mid reset m_data", m_data, 0);
    chk("mid reset fifo_count", fifo_count, 0);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("after reset no push", fifo_count, 0);
    chk("after reset idle", busy, 0);

`ifdef UART_RX_PARITY_EN
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0, 8'h00, 1'b0, "bad parity");
    bad_par = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1, 8'h07, 1'b0, "good parity");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
